// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one asynchronous-FIFO write port between N_REQ
// requesters in the wr_clk domain. Packet-aware round-robin arbitration with a
// per-grant burst limit. Each written word carries the requester index as a
// tag so the read side can demultiplex.
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int TAG_W     = 2,
   parameter int MAX_BURST = 4
) (
   input  logic                      wr_clk,
   input  logic                      wr_rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_last,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_wr_en,
   output logic [TAG_W+DATA_W-1:0]   fifo_wr_data,
   output logic [TAG_W-1:0]          grant_id,
   output logic                      busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t              state_q;
   logic [TAG_W-1:0]    gnt_q;
   logic [TAG_W-1:0]    rr_ptr_q;
   logic [3:0]          burst_cnt_q;

   logic [DATA_W-1:0]   data_arr [N_REQ];
   logic                sel_valid;
   logic                sel_last;
   logic                accept;
   logic                rel_beat;
   logic [TAG_W-1:0]    next_ptr;
   logic [N_REQ-1:0]    excl_valid;
   logic                idle_found;
   logic [TAG_W-1:0]    idle_win;
   logic                rel_found;
   logic [TAG_W-1:0]    rel_win;

   // Round-robin search: first set bit of vld at or after start, wrapping with
   // a modulo compare so non-power-of-two N_REQ works. Returns {found, index}.
   function automatic logic [TAG_W:0] rr_pick(input logic [N_REQ-1:0] vld,
                                              input logic [TAG_W-1:0] start);
      logic [TAG_W-1:0] idx;
      logic             found;
      logic [TAG_W-1:0] win;
      idx   = start;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && vld[idx]) begin
            found = 1'b1;
            win   = idx;
         end
         idx = (idx == TAG_W'(N_REQ - 1)) ? '0 : idx + TAG_W'(1);
      end
      return {found, win};
   endfunction

   // Unpack the flat payload bus so the granted lane can be selected by index.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
         assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
         assign req_ready[gi] = (state_q == GRANT) && (gnt_q == TAG_W'(gi)) && !fifo_full;
      end
   endgenerate

   assign sel_valid  = req_valid[gnt_q];
   assign sel_last   = req_last[gnt_q];
   assign accept     = (state_q == GRANT) && sel_valid && !fifo_full;
   // A grant ends on end-of-packet or when the burst allowance is used up.
   assign rel_beat   = accept && (sel_last || (burst_cnt_q == 4'(MAX_BURST - 1)));
   assign next_ptr   = (gnt_q == TAG_W'(N_REQ - 1)) ? '0 : gnt_q + TAG_W'(1);
   // The releasing requester may not win the immediate re-arbitration.
   assign excl_valid = req_valid & ~(N_REQ'(1) << gnt_q);

   assign {idle_found, idle_win} = rr_pick(req_valid, rr_ptr_q);
   assign {rel_found, rel_win}   = rr_pick(excl_valid, next_ptr);

   assign fifo_wr_en   = accept;
   assign fifo_wr_data = {gnt_q, data_arr[gnt_q]};
   assign grant_id     = gnt_q;
   assign busy         = (state_q == GRANT);

   // Arbitration FSM: grant, burst counting, release and back-to-back handover.
   always_ff @(posedge wr_clk or negedge wr_rst) begin
      if (!wr_rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (idle_found) begin
                  gnt_q       <= idle_win;
                  burst_cnt_q <= '0;
                  state_q     <= GRANT;
               end
            end
            GRANT: begin
               // A full FIFO or a dropped valid simply holds everything.
               if (accept) begin
                  if (rel_beat) begin
                     rr_ptr_q    <= next_ptr;
                     burst_cnt_q <= '0;
                     if (rel_found) begin
                        gnt_q <= rel_win;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     burst_cnt_q <= burst_cnt_q + 4'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scoreboard bench. Stimulus pushes the
// hand-ordered FIFO words into exp_q; a monitor pops on every fifo_wr_en.
// Directed point checks are queued and evaluated by the same monitor.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TW = 2;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic [3:0]    gap;
   } beat_t;

   logic              wr_clk = 1'b0;
   logic              wr_rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_last;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              fifo_full;
   logic              fifo_wr_en;
   logic [TW+DW-1:0]  fifo_wr_data;
   logic [TW-1:0]     grant_id;
   logic              busy;

   beat_t             drv_q [N][$];
   logic [TW+DW-1:0]  exp_q [$];
   string             chk_nm [$];
   int                chk_act [$];
   int                chk_exp [$];
   int                n_vec = 0;
   int                n_fail = 0;
   logic              flush = 1'b0;
   int                gap_cnt [N];

   fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW), .MAX_BURST(4)) dut (
      .wr_clk      (wr_clk),
      .wr_rst      (wr_rst),
      .req_valid   (req_valid),
      .req_last    (req_last),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .fifo_full   (fifo_full),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_wr_data(fifo_wr_data),
      .grant_id    (grant_id),
      .busy        (busy)
   );

   always #5 wr_clk = ~wr_clk;

   // Requester model: holds each beat until accepted, honours per-beat gaps.
   initial begin
      logic [N-1:0] hs;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      for (int i = 0; i < N; i++) gap_cnt[i] = 0;
      forever begin
         @(negedge wr_clk);
         hs = req_valid & req_ready;
         @(posedge wr_clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (flush) begin
               drv_q[i].delete();
               req_valid[i] = 1'b0;
               req_last[i]  = 1'b0;
               gap_cnt[i]   = 0;
            end else begin
               if (hs[i]) begin
                  void'(drv_q[i].pop_front());
                  req_valid[i] = 1'b0;
                  req_last[i]  = 1'b0;
               end
               if (!req_valid[i] && drv_q[i].size() > 0) begin
                  if (gap_cnt[i] < int'(drv_q[i][0].gap)) begin
                     gap_cnt[i]++;
                  end else begin
                     req_valid[i]          = 1'b1;
                     req_last[i]           = drv_q[i][0].last;
                     req_data[i*DW +: DW]  = drv_q[i][0].data;
                     gap_cnt[i]            = 0;
                  end
               end
            end
         end
      end
   end

   // Monitor: scoreboard on FIFO writes plus queued directed checks.
   initial begin
      logic [TW+DW-1:0] exp_w;
      string nm;
      int    a;
      int    e;
      forever begin
         @(negedge wr_clk);
         if (wr_rst === 1'b1 && fifo_wr_en === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL fifo_word: got tag=%0d data=%h, required no write",
                        fifo_wr_data[TW+DW-1:DW], fifo_wr_data[DW-1:0]);
            end else begin
               exp_w = exp_q.pop_front();
               if (fifo_wr_data !== exp_w) begin
                  n_fail++;
                  $display("FAIL fifo_word: got tag=%0d data=%h, required tag=%0d data=%h",
                           fifo_wr_data[TW+DW-1:DW], fifo_wr_data[DW-1:0],
                           exp_w[TW+DW-1:DW], exp_w[DW-1:0]);
               end else begin
                  $display("write tag=%0d data=%h ok", fifo_wr_data[TW+DW-1:DW], fifo_wr_data[DW-1:0]);
               end
            end
         end
         while (chk_nm.size() > 0) begin
            nm = chk_nm.pop_front();
            a  = chk_act.pop_front();
            e  = chk_exp.pop_front();
            n_vec++;
            if (a != e) begin
               n_fail++;
               $display("FAIL %s: got %0d required %0d", nm, a, e);
            end else begin
               $display("check %s = %0d ok", nm, a);
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      chk_nm.push_back(nm);
      chk_act.push_back(act);
      chk_exp.push_back(exp);
   endtask

   task automatic send(input int r, input logic [7:0] d, input bit last, input int gap);
      beat_t b;
      b.data = d;
      b.last = last;
      b.gap  = 4'(gap);
      drv_q[r].push_back(b);
   endtask

   task automatic expw(input int tag, input logic [7:0] d);
      exp_q.push_back({2'(tag), d});
   endtask

   function automatic bit drv_empty();
      bit e = 1'b1;
      for (int i = 0; i < N; i++) if (drv_q[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic wait_idle(input string nm);
      bit done = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge wr_clk);
         if (exp_q.size() == 0 && busy == 1'b0 && req_valid == '0 && drv_empty()) done = 1'b1;
      end
      if (!done) chk({nm, "_idle_timeout"}, 0, 1);
   endtask

   task automatic wait_wr(input string nm);
      bit got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
         @(negedge wr_clk);
         if (fifo_wr_en) got = 1'b1;
      end
      if (!got) chk({nm, "_write_timeout"}, 0, 1);
   endtask

   // Stimulus: directed scenarios with hand-computed word order.
   initial begin
      bit got;
      int cnt;
      wr_rst    = 1'b0;
      fifo_full = 1'b0;
      repeat (2) @(negedge wr_clk);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_fifo_wr_en", int'(fifo_wr_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_grant_id", int'(grant_id), 0);
      wr_rst = 1'b1;
      @(negedge wr_clk);

      // Requester 2 alone, 3-beat packet; leaves rr_ptr=3.
      send(2, 8'h20, 0, 0); send(2, 8'h21, 0, 0); send(2, 8'h22, 1, 0);
      expw(2, 8'h20); expw(2, 8'h21); expw(2, 8'h22);
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge wr_clk);
         if (req_valid[2]) got = 1'b1;
      end
      chk("t1_valid_seen", int'(got), 1);
      chk("t1_busy_same_cycle", int'(busy), 0);
      @(negedge wr_clk);
      chk("t1_busy_next_cycle", int'(busy), 1);
      chk("t1_grant_id", int'(grant_id), 2);
      chk("t1_first_write", int'(fifo_wr_en), 1);
      wait_idle("t1");

      // Requesters 0 and 1, two 2-beat packets each, back to back; rr_ptr 3 -> 2.
      for (int p = 0; p < 2; p++) begin
         send(0, 8'h01 + 8'(2*p), 0, 0); send(0, 8'h02 + 8'(2*p), 1, 0);
         send(1, 8'h11 + 8'(2*p), 0, 0); send(1, 8'h12 + 8'(2*p), 1, 0);
      end
      expw(0, 8'h01); expw(0, 8'h02); expw(1, 8'h11); expw(1, 8'h12);
      expw(0, 8'h03); expw(0, 8'h04); expw(1, 8'h13); expw(1, 8'h14);
      wait_wr("t2");
      cnt = 0;
      while (fifo_wr_en && cnt < 20) begin
         cnt++;
         @(negedge wr_clk);
      end
      chk("t2_back_to_back_writes", cnt, 8);
      wait_idle("t2");

      // Requester 3 8-beat packet vs waiting requester 0; burst limit interleave.
      for (int b = 0; b < 8; b++) send(3, 8'h30 + 8'(b), (b == 7), 0);
      send(0, 8'h05, 0, 0); send(0, 8'h06, 1, 0);
      for (int b = 0; b < 4; b++) expw(3, 8'h30 + 8'(b));
      expw(0, 8'h05); expw(0, 8'h06);
      for (int b = 4; b < 8; b++) expw(3, 8'h30 + 8'(b));
      wait_idle("t3");

      // Requester 1 5-beat packet with a 5-cycle full stall after beat 2.
      for (int b = 0; b < 5; b++) send(1, 8'h40 + 8'(b), (b == 4), 0);
      send(2, 8'h50, 1, 0);
      for (int b = 0; b < 4; b++) expw(1, 8'h40 + 8'(b));
      expw(2, 8'h50);
      expw(1, 8'h44);
      cnt = 0;
      for (int t = 0; t < 100 && cnt < 2; t++) begin
         @(negedge wr_clk);
         if (fifo_wr_en) cnt++;
      end
      chk("t4_two_beats_before_stall", cnt, 2);
      @(posedge wr_clk);
      #1 fifo_full = 1'b1;
      for (int s = 0; s < 5; s++) begin
         @(negedge wr_clk);
         chk("t4_stall_ready1", int'(req_ready[1]), 0);
         chk("t4_stall_wr_en", int'(fifo_wr_en), 0);
         chk("t4_stall_grant_id", int'(grant_id), 1);
         @(posedge wr_clk);
         #1;
      end
      fifo_full = 1'b0;
      @(negedge wr_clk);
      chk("t4_resume_write", int'(fifo_wr_en), 1);
      wait_idle("t4");

      // Requester 0 drops valid for 2 cycles mid-packet; requester 2 must wait.
      send(0, 8'h60, 0, 0); send(0, 8'h61, 0, 2); send(0, 8'h62, 1, 0);
      expw(0, 8'h60); expw(0, 8'h61); expw(0, 8'h62); expw(2, 8'h70);
      wait_wr("t5");
      send(2, 8'h70, 1, 0);
      for (int s = 0; s < 2; s++) begin
         @(negedge wr_clk);
         chk("t5_hold_grant_id", int'(grant_id), 0);
         chk("t5_hold_busy", int'(busy), 1);
         chk("t5_hold_no_ready2", int'(req_ready[2]), 0);
         chk("t5_hold_no_write", int'(fifo_wr_en), 0);
      end
      wait_idle("t5");

      // Move rr_ptr to 1, then reset during beat 2 of requester 1's packet.
      send(0, 8'h80, 1, 0);
      expw(0, 8'h80);
      wait_idle("t6a");
      for (int b = 0; b < 4; b++) send(1, 8'h90 + 8'(b), (b == 3), 0);
      expw(1, 8'h90);
      wait_wr("t6");
      @(posedge wr_clk);
      #3;
      wr_rst = 1'b0;
      flush  = 1'b1;
      #1;
      chk("t6_rst_req_ready", int'(req_ready), 0);
      chk("t6_rst_fifo_wr_en", int'(fifo_wr_en), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_grant_id", int'(grant_id), 0);
      repeat (2) @(negedge wr_clk);
      wr_rst = 1'b1;
      flush  = 1'b0;
      send(0, 8'hA0, 1, 0); send(1, 8'hA1, 1, 0);
      expw(0, 8'hA0); expw(1, 8'hA1);
      wait_idle("t6b");

      chk("scoreboard_drained", exp_q.size(), 0);
      repeat (3) @(negedge wr_clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

endmodule
